// File: rtl/lsu_byte_seq_pkg.sv
// lsu_byte_seq_pkg
//   Shared definitions for the byte-serial load/store unit: the dm_* access
//   type codes used by the pipeline, the LSU state encoding, and small helpers
//   that derive beat count and type legality from an access type.
//   No ports (package).

package lsu_byte_seq_pkg;

    localparam logic [2:0] DM_WORD              = 3'b000;
    localparam logic [2:0] DM_HALFWORD          = 3'b001;
    localparam logic [2:0] DM_HALFWORD_UNSIGNED = 3'b010;
    localparam logic [2:0] DM_BYTE              = 3'b011;
    localparam logic [2:0] DM_BYTE_UNSIGNED     = 3'b100;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'b00,
        LSU_ACCESS = 2'b01,
        LSU_RESP   = 2'b10
    } lsu_state_e;

    // Index of the final beat (N-1) for a legal access type.
    function automatic logic [1:0] lsu_last_idx(input logic [2:0] acc_type);
        case (acc_type)
            DM_WORD:                           return 2'd3;
            DM_HALFWORD, DM_HALFWORD_UNSIGNED: return 2'd1;
            default:                           return 2'd0;
        endcase
    endfunction

    function automatic logic lsu_type_legal(input logic [2:0] acc_type);
        return acc_type <= DM_BYTE_UNSIGNED;
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// lsu_extend
//   Combinational sign/zero extension of an assembled little-endian load
//   value, selected by access type. Also used by the WB-stage forwarding path.
//   Ports:
//     raw      in  32  assembled bytes (byte 0 in [7:0])
//     acc_type in  3   dm_* access type
//     ext      out 32  extended load data (word and unknown types pass raw)

module lsu_extend
    import lsu_byte_seq_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  acc_type,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (acc_type)
            DM_HALFWORD:          ext = {{16{raw[15]}}, raw[15:0]};
            DM_HALFWORD_UNSIGNED: ext = {16'h0000, raw[15:0]};
            DM_BYTE:              ext = {{24{raw[7]}}, raw[7:0]};
            DM_BYTE_UNSIGNED:     ext = {24'h000000, raw[7:0]};
            default:              ext = raw;
        endcase
    end

endmodule

// File: rtl/lsu_byte_seq.sv
// lsu_byte_seq
//   MEM-stage load/store initiator. Takes one access per handshake and plays
//   it out on a byte-wide memory port as 1, 2 or 4 little-endian beats, then
//   returns one registered response with extended load data.
//   Optional build macro: LSU_ALIGN_CHECK_EN -- when defined, misaligned word
//   and halfword accesses are rejected with resp_err and issue no beats.
//   Ports:
//     clk, rst                    clock, async active-high reset
//     req_valid/req_ready         pipeline handshake
//     req_we/addr/wdata/type      access descriptor
//     resp_valid/rdata/err        one-cycle response strobe and payload
//     mem_valid/ready             per-beat handshake to data memory
//     mem_we/addr/wbyte, mem_rbyte beat payload
//
//   state      | meaning
//   LSU_IDLE   | ready for a request
//   LSU_ACCESS | issuing byte beats, waiting on mem_ready
//   LSU_RESP   | response strobe cycle, returns to IDLE

module lsu_byte_seq
    import lsu_byte_seq_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [2:0]        req_type,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wbyte,
    input  logic [7:0]        mem_rbyte
);

    lsu_state_e        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [31:0]       resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wbyte_q, mem_wbyte_d;
    logic [1:0]        idx_q, idx_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        type_q, type_d;

    logic [31:0] asm_upd;
    logic [31:0] ext_data;
    logic [1:0]  idx_nxt;
    logic        misaligned;

`ifdef LSU_ALIGN_CHECK_EN
    assign misaligned = ((req_type == DM_WORD) && (req_addr[1:0] != 2'b00)) ||
                        (((req_type == DM_HALFWORD) || (req_type == DM_HALFWORD_UNSIGNED)) &&
                         req_addr[0]);
`else
    assign misaligned = 1'b0;
`endif

    // Assembly including the byte arriving this cycle, so the final beat's
    // data reaches the extender without an extra cycle.
    always_comb begin
        asm_upd = asm_q;
        asm_upd[{idx_q, 3'b000} +: 8] = mem_rbyte;
    end

    lsu_extend u_extend (
        .raw      (asm_upd),
        .acc_type (type_q),
        .ext      (ext_data)
    );

    assign idx_nxt = idx_q + 2'd1;

    always_comb begin
        state_d      = state_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wbyte_d  = mem_wbyte_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        wdata_d      = wdata_q;
        type_d       = type_q;
        case (state_q)
            LSU_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    wdata_d     = req_wdata;
                    type_d      = req_type;
                    idx_d       = 2'd0;
                    asm_d       = 32'h0;
                    if (lsu_type_legal(req_type) && !misaligned) begin
                        state_d     = LSU_ACCESS;
                        mem_valid_d = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = req_addr;
                        mem_wbyte_d = req_wdata[7:0];
                    end else begin
                        // Rejected: straight to the response, memory port untouched.
                        state_d      = LSU_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end
                end
            end
            LSU_ACCESS: begin
                if (mem_ready) begin
                    if (!mem_we_q) begin
                        asm_d = asm_upd;
                    end
                    idx_d = idx_nxt;
                    if (idx_q == lsu_last_idx(type_q)) begin
                        state_d      = LSU_RESP;
                        mem_valid_d  = 1'b0;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = mem_we_q ? 32'h0 : ext_data;
                    end else begin
                        mem_addr_d  = mem_addr_q + ADDR_W'(1);
                        mem_wbyte_d = wdata_q[{idx_nxt, 3'b000} +: 8];
                    end
                end
            end
            LSU_RESP: begin
                state_d     = LSU_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = LSU_IDLE;
                req_ready_d = 1'b1;
                mem_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= LSU_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wbyte_q  <= 8'h00;
            idx_q        <= 2'd0;
            asm_q        <= 32'h0;
            wdata_q      <= 32'h0;
            type_q       <= 3'd0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wbyte_q  <= mem_wbyte_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            wdata_q      <= wdata_d;
            type_q       <= type_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_valid  = mem_valid_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wbyte  = mem_wbyte_q;

endmodule

// File: tb/tb_lsu_byte_seq.sv
// tb_lsu_byte_seq
//   Bench for lsu_byte_seq: a byte memory responder with configurable stall,
//   a reference memory and access model, directed scenarios and a randomized
//   sweep. Build with +define+LSU_ALIGN_CHECK_EN to cover the alignment option.

module tb_lsu_byte_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_type;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wbyte;
    logic [7:0]  mem_rbyte = 8'h00;

    lsu_byte_seq #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_type   (req_type),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wbyte  (mem_wbyte),
        .mem_rbyte  (mem_rbyte)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    bit [7:0] dut_mem [bit [31:0]];
    bit [7:0] ref_mem [bit [31:0]];

    logic [31:0] beat_addr [$];
    logic        beat_we   [$];
    logic [7:0]  beat_wb   [$];

    int   stall_fixed = 0;
    int   stall_max   = 0;
    bit   rand_stall  = 1'b0;
    int   cur_stall   = 0;
    int   wait_cnt    = 0;
    int   stab_err    = 0;
    logic [31:0] hold_addr;
    logic        hold_we;
    logic [7:0]  hold_wb;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] dut_rd(input logic [31:0] a);
        return dut_mem.exists(a) ? dut_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    // Number of memory beats an access should make; 0 means rejected.
    function automatic int exp_beats(input logic [2:0] t, input logic [31:0] a);
        if (t > 3'd4) return 0;
`ifdef LSU_ALIGN_CHECK_EN
        if (t == 3'd0 && a[1:0] != 2'b00) return 0;
        if ((t == 3'd1 || t == 3'd2) && a[0]) return 0;
`endif
        if (t == 3'd0) return 4;
        if (t <= 3'd2) return 2;
        return 1;
    endfunction

    // Load result from the reference memory, extended arithmetically.
    function automatic logic [31:0] exp_load(input logic [2:0] t, input logic [31:0] a);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < exp_beats(t, a); i++)
            v = v + ({24'h0, ref_rd(a + 32'(i))} << (8 * i));
        case (t)
            3'd1:    return (v & 32'hFFFF) - (v[15] ? 32'h10000 : 32'h0);
            3'd2:    return v & 32'hFFFF;
            3'd3:    return (v & 32'hFF) - (v[7] ? 32'h100 : 32'h0);
            3'd4:    return v & 32'hFF;
            default: return v;
        endcase
    endfunction

    // Memory responder: everything happens at negedge, away from the DUT edge.
    always @(negedge clk) begin
        if (rst || !mem_valid) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
            cur_stall = rand_stall ? int'($urandom_range(stall_max, 0)) : stall_fixed;
        end else begin
            if (mem_ready) begin
                wait_cnt  = 0;
                cur_stall = rand_stall ? int'($urandom_range(stall_max, 0)) : stall_fixed;
            end
            if (wait_cnt == 0) begin
                hold_addr = mem_addr;
                hold_we   = mem_we;
                hold_wb   = mem_wbyte;
            end else if (mem_addr !== hold_addr || mem_we !== hold_we || mem_wbyte !== hold_wb) begin
                stab_err++;
            end
            if (wait_cnt >= cur_stall) begin
                mem_ready = 1'b1;
                mem_rbyte = dut_rd(mem_addr);
                beat_addr.push_back(mem_addr);
                beat_we.push_back(mem_we);
                beat_wb.push_back(mem_wbyte);
                if (mem_we) dut_mem[mem_addr] = mem_wbyte;
            end else begin
                mem_ready = 1'b0;
                mem_rbyte = 8'($urandom);
            end
            wait_cnt++;
        end
    end

    // Issue one request (called just after a negedge) and observe it to the
    // cycle after its response.
    task automatic run_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] t, output logic [31:0] rdata, output logic err,
                              output int lat, output bit rdy_hi, output bit resp_after,
                              output bit post_rdy);
        beat_addr.delete();
        beat_we.delete();
        beat_wb.delete();
        rdata     = 32'hDEADBEEF;
        err       = 1'bx;
        lat       = 0;
        rdy_hi    = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_type  = t;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_type  = 3'($urandom);
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (req_ready) rdy_hi = 1'b1;
            if (resp_valid) begin
                lat   = k;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
        @(negedge clk);
        resp_after = resp_valid;
        post_rdy   = req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_type = 3'd0;
        #12;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        n_cmp++; if (resp_rdata !== 32'h0) begin n_bad++; $display("FAIL reset_resp_rdata got %h want 0", resp_rdata); end
        n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
        n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL reset_mem_valid got %b want 0", mem_valid); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
        n_cmp++; if (mem_wbyte !== 8'h0) begin n_bad++; $display("FAIL reset_mem_wbyte got %h want 0", mem_wbyte); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_store();
        logic [31:0] rd; logic er; int lat; bit rh, ra, pr;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
        rand_stall = 1'b0; stall_fixed = 0;
        run_access(1'b1, 32'h10, 32'h11223344, 3'd0, rd, er, lat, rh, ra, pr);
        for (int i = 0; i < 4; i++) ref_mem[32'h10 + 32'(i)] = exp_b[i];
        n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL wst_latency got %0d want 5", lat); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL wst_err got %b want 0", er); end
        n_cmp++; if (rd !== 32'h0) begin n_bad++; $display("FAIL wst_rdata got %h want 0", rd); end
        n_cmp++; if (beat_addr.size() != 4) begin n_bad++; $display("FAIL wst_beats got %0d want 4", beat_addr.size()); end
        for (int i = 0; i < 4 && i < beat_addr.size(); i++) begin
            n_cmp++;
            if (beat_addr[i] !== 32'h10 + 32'(i) || beat_wb[i] !== exp_b[i] || beat_we[i] !== 1'b1) begin
                n_bad++;
                $display("FAIL wst_beat%0d got %h/%h/%b want %h/%h/1", i, beat_addr[i], beat_wb[i], beat_we[i],
                         32'h10 + 32'(i), exp_b[i]);
            end
        end
        n_cmp++; if (rh || ra || !pr) begin n_bad++; $display("FAIL wst_handshake got rdy_busy=%b resp_after=%b rdy_after=%b want 0/0/1", rh, ra, pr); end
    endtask

    task automatic test_byte_load();
        logic [31:0] rd; logic er; int lat; bit rh, ra, pr;
        dut_mem[32'h20] = 8'h80; ref_mem[32'h20] = 8'h80;
        rand_stall = 1'b0; stall_fixed = 0;
        run_access(1'b0, 32'h20, 32'h0, 3'd3, rd, er, lat, rh, ra, pr);
        n_cmp++; if (rd !== 32'hFFFFFF80) begin n_bad++; $display("FAIL byte_signed got %h want ffffff80", rd); end
        n_cmp++; if (lat != 2 || beat_addr.size() != 1) begin n_bad++; $display("FAIL byte_signed_timing got lat=%0d beats=%0d want 2/1", lat, beat_addr.size()); end
        run_access(1'b0, 32'h20, 32'h0, 3'd4, rd, er, lat, rh, ra, pr);
        n_cmp++; if (rd !== 32'h00000080 || er !== 1'b0) begin n_bad++; $display("FAIL byte_unsigned got %h err=%b want 00000080 err=0", rd, er); end
    endtask

    task automatic test_half_stall();
        logic [31:0] rd; logic er; int lat; bit rh, ra, pr;
        dut_mem[32'h30] = 8'hFE; dut_mem[32'h31] = 8'h7F;
        ref_mem[32'h30] = 8'hFE; ref_mem[32'h31] = 8'h7F;
        rand_stall = 1'b0; stall_fixed = 3; stab_err = 0;
        run_access(1'b0, 32'h30, 32'h0, 3'd1, rd, er, lat, rh, ra, pr);
        n_cmp++; if (rd !== 32'h00007FFE) begin n_bad++; $display("FAIL half_stall_rdata got %h want 00007ffe", rd); end
        n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL half_stall_stable got %0d changes want 0", stab_err); end
        n_cmp++; if (rh) begin n_bad++; $display("FAIL half_stall_ready got busy-ready=1 want 0"); end
        n_cmp++; if (lat != 9) begin n_bad++; $display("FAIL half_stall_latency got %0d want 9", lat); end
        stall_fixed = 0;
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int lat; bit rh, ra, pr; int n;
        logic [31:0] ex;
        rand_stall = 1'b0; stall_fixed = 0;
        n  = exp_beats(3'd0, 32'hFFFFFFFE);
        ex = (n == 0) ? 32'h0 : exp_load(3'd0, 32'hFFFFFFFE);
        run_access(1'b0, 32'hFFFFFFFE, 32'h0, 3'd0, rd, er, lat, rh, ra, pr);
        n_cmp++; if (beat_addr.size() != n) begin n_bad++; $display("FAIL wrap_beats got %0d want %0d", beat_addr.size(), n); end
        for (int i = 0; i < n && i < beat_addr.size(); i++) begin
            n_cmp++;
            if (beat_addr[i] !== 32'hFFFFFFFE + 32'(i)) begin
                n_bad++; $display("FAIL wrap_addr%0d got %h want %h", i, beat_addr[i], 32'hFFFFFFFE + 32'(i));
            end
        end
        n_cmp++; if (rd !== ex || er !== (n == 0)) begin n_bad++; $display("FAIL wrap_resp got %h err=%b want %h err=%b", rd, er, ex, n == 0); end
        n_cmp++; if (lat != n + 1) begin n_bad++; $display("FAIL wrap_latency got %0d want %0d", lat, n + 1); end
    endtask

    task automatic test_illegal();
        logic [31:0] rd; logic er; int lat; bit rh, ra, pr;
        rand_stall = 1'b0; stall_fixed = 0;
        run_access(1'b0, 32'h50, 32'h12345678, 3'd7, rd, er, lat, rh, ra, pr);
        n_cmp++; if (beat_addr.size() != 0) begin n_bad++; $display("FAIL illegal_beats got %0d want 0", beat_addr.size()); end
        n_cmp++; if (er !== 1'b1 || rd !== 32'h0) begin n_bad++; $display("FAIL illegal_resp got err=%b rdata=%h want err=1 rdata=0", er, rd); end
        n_cmp++; if (lat != 1) begin n_bad++; $display("FAIL illegal_latency got %0d want 1", lat); end
        n_cmp++; if (!pr || ra) begin n_bad++; $display("FAIL illegal_after got rdy=%b resp=%b want 1/0", pr, ra); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; bit rh, ra, pr;
        bit found;
        bit resp_seen;
        found = 1'b0; resp_seen = 1'b0;
        beat_addr.delete(); beat_we.delete(); beat_wb.delete();
        rand_stall = 1'b0; stall_fixed = 4;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hA1B2C3D4; req_type = 3'd0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mem_valid && mem_addr == 32'h41) begin found = 1'b1; break; end
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL rstmid_beat2 got none want beat at 00000041"); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (mem_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_mem_valid got %b want 0", mem_valid); end
        n_cmp++; if (beat_addr.size() != 1) begin n_bad++; $display("FAIL rstmid_beats got %0d want 1", beat_addr.size()); end
        repeat (3) begin @(negedge clk); if (resp_valid) resp_seen = 1'b1; end
        rst = 1'b0;
        repeat (3) begin @(negedge clk); if (resp_valid) resp_seen = 1'b1; end
        n_cmp++; if (resp_seen) begin n_bad++; $display("FAIL rstmid_resp got resp_valid=1 want 0"); end
        // Beat 1 completed before the reset, so byte 0x40 holds D4.
        ref_mem[32'h40] = 8'hD4;
        stall_fixed = 0;
        run_access(1'b0, 32'h40, 32'h0, 3'd3, rd, er, lat, rh, ra, pr);
        n_cmp++; if (rd !== 32'hFFFFFFD4 || er !== 1'b0 || lat != 2) begin
            n_bad++; $display("FAIL rstmid_next got %h err=%b lat=%0d want ffffffd4 err=0 lat=2", rd, er, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat; bit rh, ra, pr;
        logic we; logic [2:0] t; logic [31:0] a, wd, ex; int n;
        rand_stall = 1'b1; stall_max = 2; stab_err = 0;
        for (int it = 0; it < 60; it++) begin
            we = 1'($urandom);
            t  = ($urandom_range(9, 0) == 0) ? 3'($urandom_range(7, 5)) : 3'($urandom_range(4, 0));
            a  = ($urandom_range(3, 0) == 0) ? 32'hFFFFFFFC + $urandom_range(3, 0) : 32'h100 + $urandom_range(15, 0);
            wd = $urandom;
            n  = exp_beats(t, a);
            ex = (n > 0 && !we) ? exp_load(t, a) : 32'h0;
            run_access(we, a, wd, t, rd, er, lat, rh, ra, pr);
            if (we) for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = 8'(wd >> (8 * i));
            n_cmp++; if (lat == 0) begin n_bad++; $display("FAIL rnd%0d_timeout got no response want one", it); end
            n_cmp++; if (er !== (n == 0) || rd !== ex) begin
                n_bad++; $display("FAIL rnd%0d_resp t=%0d a=%h we=%b got %h err=%b want %h err=%b", it, t, a, we, rd, er, ex, n == 0);
            end
            n_cmp++; if (beat_addr.size() != n) begin n_bad++; $display("FAIL rnd%0d_beats got %0d want %0d", it, beat_addr.size(), n); end
            for (int i = 0; i < n && i < beat_addr.size(); i++) begin
                n_cmp++;
                if (beat_addr[i] !== a + 32'(i) || beat_we[i] !== we || (we && beat_wb[i] !== 8'(wd >> (8 * i)))) begin
                    n_bad++;
                    $display("FAIL rnd%0d_beat%0d got %h/%b/%h want %h/%b/%h", it, i, beat_addr[i], beat_we[i], beat_wb[i],
                             a + 32'(i), we, 8'(wd >> (8 * i)));
                end
            end
            n_cmp++; if (rh || ra || !pr) begin n_bad++; $display("FAIL rnd%0d_handshake got %b/%b/%b want 0/0/1", it, rh, ra, pr); end
        end
        n_cmp++; if (stab_err != 0) begin n_bad++; $display("FAIL rnd_stable got %0d changes want 0", stab_err); end
        rand_stall = 1'b0;
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_load();
        test_half_stall();
        test_wrap();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_byte_seq.md
Name: lsu_byte_seq

Overview:
- Load/store initiator for the MEM stage of the pipeline CPU.
- Accepts one load or store per handshake from the pipeline, using the `dm_*` access types from defines.v.
- Drives a byte-wide data-memory port as a sequence of 1, 2 or 4 little-endian byte beats.
- Assembles and sign/zero-extends load data, then returns one response; the pipeline stalls on req_ready=0.

Parameters:
- ADDR_W, 32, byte address width of both the pipeline request and the memory port.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  1  pipeline presents an access
- req_ready  out  1  block accepts the access this cycle
- req_we  in  1  1=store, 0=load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data
- req_type  in  3  access type: `dm_word`=3'b000, `dm_halfword`=3'b001, `dm_halfword_unsigned`=3'b010, `dm_byte`=3'b011, `dm_byte_unsigned`=3'b100
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  access rejected; no memory beats were issued
- mem_valid  out  1  byte beat request
- mem_ready  in  1  memory accepts or completes the beat
- mem_we  out  1  beat is a write
- mem_addr  out  ADDR_W  beat byte address
- mem_wbyte  out  8  write byte
- mem_rbyte  in  8  read byte, valid in the same cycle as mem_ready

Behaviour:
- Reset values (asynchronous): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_valid=0, mem_we=0, mem_addr=0, mem_wbyte=0, beat index=0, assembly register=0.
- A reset asserted mid-operation aborts the access; mem_valid falls with rst and no response is produced.
- Beat count N: word=4, halfword/halfword_unsigned=2, byte/byte_unsigned=1.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/addr/wdata/type and clear index and assembly.
  - A valid type goes to ACCESS.
  - A type of 3'b101..3'b111 goes to RESP with err=1.
- ACCESS:
  - mem_valid=1, mem_addr=base+idx (mod 2^ADDR_W, so 0xFFFFFFFF+1 wraps to 0), mem_we=we, mem_wbyte=wdata[8*idx+:8].
  - All mem_* outputs stay stable while mem_ready=0.
  - On mem_ready: for loads, store mem_rbyte into assembly byte idx. Then idx++; when idx==N-1 go to RESP, otherwise stay.
  - mem_valid is registered; a mem_ready asserted during the last beat never produces an extra beat.
- RESP:
  - resp_valid=1 for exactly one cycle, with no back-pressure.
  - resp_rdata:
    - byte: sign-extend bit7.
    - byte_unsigned: zero-extend.
    - halfword: sign-extend bit15.
    - halfword_unsigned: zero-extend.
    - word: raw.
    - store or error: 0.
  - Next state is IDLE.
  - resp_valid, resp_rdata and resp_err are registered and return to 0 the cycle after RESP.
- req_ready=0 in ACCESS and RESP. A new request can be accepted the cycle after RESP.
- Latency with mem_ready tied 1: accept at T, beats T+1..T+N, resp_valid at T+N+1.
- Reads have no side effects. Stores never read memory.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined:
  - Word with addr[1:0]!=0, or halfword with addr[0]!=0, is rejected.
  - The request is accepted, goes IDLE->RESP with resp_err=1 and resp_rdata=0, and issues zero memory beats.
- Undefined:
  - Misaligned accesses proceed byte-by-byte at consecutive addresses with no error.
  - Only illegal req_type raises resp_err.

Decomposition:
- defines.v (shared): the `dm_*` type codes, plus new `lsu_idle`/`lsu_access`/`lsu_resp` state encodings (2'b00/01/10).
- One natural sub-module, lsu_extend: combinational N-byte assembly plus sign/zero extension, selected by type. It is reused by the WB-stage forwarding path.

Test Plan:
- Word store 0x11223344 to 0x10, mem_ready=1 -> beats at 0x10..0x13 with bytes 44,33,22,11; resp_valid at T+5, resp_err=0, resp_rdata=0.
- Byte load from 0x20 returning 0x80 -> one beat; `dm_byte` gives resp_rdata=0xFFFFFF80; repeated with `dm_byte_unsigned` gives 0x00000080.
- Halfword load from 0x30 returning 0xFE,0x7F with mem_ready low 3 cycles on each beat -> mem_addr/mem_valid held stable; resp_rdata=0x00007FFE; req_ready=0 throughout.
- Word load at 0xFFFFFFFE -> beats at FFFFFFFE, FFFFFFFF, 00000000, 00000001. With LSU_ALIGN_CHECK_EN: zero beats, resp_err=1 at T+1.
- req_type=3'b111 -> no beats, resp_err=1 one cycle after accept, then req_ready=1.
- rst asserted during beat 2 of a word store -> mem_valid=0 immediately, no resp_valid; the next request completes normally.
